// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks.
// FSM state encoding and default operand width.
package serial_arith_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
// Built from two cascaded half-subtractors.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hd;
  logic hb1;
  logic hb2;

  assign hd   = a ^ b;
  assign hb1  = ~a & b;
  assign d    = hd ^ bin;
  assign hb2  = ~hd & bin;
  assign bout = hb1 | hb2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, start/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output o_OVERFLOW.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_START,
  input  logic [WIDTH-1:0] i_MINUEND,
  input  logic [WIDTH-1:0] i_SUBTRAHEND,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic [WIDTH-1:0] o_DIFF,
  output logic             o_BORROW
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             o_OVERFLOW
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             borrow_nx;
  logic [WIDTH-1:0] d_sh_nx;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (borrow_nx)
  );

  assign d_sh_nx = {d_bit, d_sh[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits are shifted out, so keep copies.
  logic a_msb;
  logic b_msb;
`endif

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      d_sh     <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      o_BUSY   <= 1'b0;
      o_DONE   <= 1'b0;
      o_DIFF   <= '0;
      o_BORROW <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      o_OVERFLOW <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (i_START) begin
            a_sh   <= i_MINUEND;
            b_sh   <= i_SUBTRAHEND;
            d_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            o_BUSY <= 1'b1;
            state  <= SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb <= i_MINUEND[WIDTH-1];
            b_msb <= i_SUBTRAHEND[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          d_sh   <= d_sh_nx;
          borrow <= borrow_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            o_DIFF   <= d_sh_nx;
            o_BORROW <= borrow_nx;
            o_DONE   <= 1'b1;
            state    <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            o_OVERFLOW <= (a_msb != b_msb) &&
                          (d_sh_nx[WIDTH-1] != a_msb);
`endif
          end
        end
        DONE: begin
          o_DONE <= 1'b0;
          o_BUSY <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_DONE <= 1'b0;
          o_BUSY <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
